// File: rtl/simplez_loader.sv
// simplez_loader: UART boot loader for the Simplez processor.
// Receives a framed program (SYNC 0xA5, 9-bit word count, N x {W_HI, W_LO}),
// writes each 12-bit word into program RAM and releases cpu_rstn after a
// complete, well-formed frame.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte (CHK) before the processor is released.
module simplez_loader #(
    parameter int AW      = 9,
    parameter int DW      = 12,
    parameter int TIMEOUT = 1200000
) (
    input  logic          clk,
    input  logic          rstn_ini,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    output logic          cpu_rstn,
    output logic          busy,
    output logic          err
);

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_W_HI,
        S_W_LO,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          accept;
    logic          start;
    logic          set_err;
    logic          timed_out;
    logic [8:0]    left;
    logic [3:0]    hi;
    logic [TW-1:0] timer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    acc;
`endif

    assign rx_ready = (state != S_WRITE);
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign accept   = rx_valid && rx_ready;

    // State register
    always_ff @(posedge clk or negedge rstn_ini) begin
        if (!rstn_ini) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode, frame error and frame start detection
    always_comb begin
        next_state = state;
        start      = 1'b0;
        set_err    = 1'b0;
        timed_out  = busy && !accept && (timer == TW'(TIMEOUT - 1));
        if (timed_out) begin
            next_state = S_IDLE;
            set_err    = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept && rx_data == SYNC) begin
                        next_state = S_CNT_LO;
                        start      = 1'b1;
                    end
                end
                S_CNT_LO: begin
                    if (accept) next_state = S_CNT_HI;
                end
                S_CNT_HI: begin
                    if (accept) begin
                        if (rx_data[7:1] != 7'd0) begin
                            next_state = S_IDLE;
                            set_err    = 1'b1;
                        end else begin
                            next_state = S_W_HI;
                        end
                    end
                end
                S_W_HI: begin
                    if (accept) begin
                        if (rx_data[7:4] != 4'd0) begin
                            next_state = S_IDLE;
                            set_err    = 1'b1;
                        end else begin
                            next_state = S_W_LO;
                        end
                    end
                end
                S_W_LO: begin
                    if (accept) next_state = S_WRITE;
                end
                S_WRITE: begin
                    if (left != 9'd0) begin
                        next_state = S_W_HI;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        next_state = S_CHK;
`else
                        next_state = S_DONE;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        if (rx_data == acc) begin
                            next_state = S_DONE;
                        end else begin
                            next_state = S_IDLE;
                            set_err    = 1'b1;
                        end
                    end
                end
`endif
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Frame datapath: word counter, address, write strobe, status flags, timer
    always_ff @(posedge clk or negedge rstn_ini) begin
        if (!rstn_ini) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            cpu_rstn <= 1'b0;
            err      <= 1'b0;
            timer    <= '0;
            left     <= '0;
            hi       <= '0;
        end else begin
            mem_we   <= 1'b0;
            // cpu_rstn is a registered copy of "DONE next cycle", so it rises
            // together with the DONE state and falls on the next SYNC.
            cpu_rstn <= (next_state == S_DONE);

            if (set_err) begin
                err <= 1'b1;
            end else if (start) begin
                err <= 1'b0;
            end

            if (!busy || accept) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            if (start) begin
                mem_addr <= '0;
            end

            case (state)
                S_CNT_LO: if (accept) left[7:0] <= rx_data;
                S_CNT_HI: if (accept) left[8]   <= rx_data[0];
                S_W_HI:   if (accept) hi        <= rx_data[3:0];
                S_W_LO: begin
                    if (accept) begin
                        mem_data <= DW'({hi, rx_data});
                        mem_we   <= 1'b1;
                    end
                end
                S_WRITE: begin
                    // Address only advances when another word follows, so the
                    // last write of a 512-word frame never wraps back to 0.
                    if (left != 9'd0) begin
                        left     <= left - 1'b1;
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every frame byte after SYNC and before CHK
    always_ff @(posedge clk or negedge rstn_ini) begin
        if (!rstn_ini) begin
            acc <= '0;
        end else if (start) begin
            acc <= '0;
        end else if (accept && (state == S_CNT_LO || state == S_CNT_HI ||
                                state == S_W_HI   || state == S_W_LO)) begin
            acc <= acc ^ rx_data;
        end
    end
`endif

endmodule

// File: doc/simplez_loader.md
SIMPLEZ_LOADER -- requirements
Module: simplez_loader

Interface
REQ-001 Parameter AW, 9, memory address width (words).
REQ-002 Parameter DW, 12, memory data width.
REQ-003 Parameter TIMEOUT, 1200000, max clk cycles between bytes inside a frame.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rstn_ini  input  1  asynchronous, active-low reset.
REQ-006 rx_data  input  8  byte from the UART receiver.
REQ-007 rx_valid  input  1  rx_data valid this cycle.
REQ-008 rx_ready  output  1  loader accepts byte; transfer when rx_valid and rx_ready are both high.
REQ-009 mem_addr  output  AW  RAM write address.
REQ-010 mem_data  output  DW  RAM write data.
REQ-011 mem_we  output  1  one-cycle RAM write strobe.
REQ-012 cpu_rstn  output  1  processor reset, active-low; low while no valid program is loaded.
REQ-013 busy  output  1  frame in progress.
REQ-014 err  output  1  sticky frame error.

Function
REQ-015 Frame format: SYNC 0xA5, CNT_LO, CNT_HI (bit0 = count bit8, bits 7:1 zero), then N = count+1 words as W_HI (bits 3:0 = data[11:8], bits 7:4 zero) and W_LO (data[7:0]), then CHK (only when the checksum feature is compiled in).
REQ-016 FSM states: IDLE, CNT_LO, CNT_HI, W_HI, W_LO, WRITE, CHK, DONE; DONE is also the resting state after a good load.
REQ-017 IDLE/DONE: byte 0xA5 -> CNT_LO, cpu_rstn driven low, err cleared, busy high; any other byte is discarded with no state change.
REQ-018 CNT_HI with bits 7:1 nonzero, or W_HI with bits 7:4 nonzero -> err set, back to IDLE.
REQ-019 After W_LO is accepted -> WRITE: mem_we high for exactly one cycle with mem_addr = word index (starting at 0) and mem_data = {W_HI[3:0], W_LO}; rx_ready low in WRITE.
REQ-020 After WRITE: if words remain -> W_HI with address incremented; otherwise -> CHK (feature in) or DONE (feature out).
REQ-021 Address increments mod 2^AW; count 511 writes addresses 0..511 with no wrap-around write.
REQ-022 rx_ready is high in every state except WRITE.
REQ-023 Inter-byte timer resets on every accepted byte while busy; reaching TIMEOUT cycles -> err set, IDLE.
REQ-024 A byte value of 0xA5 inside a frame is treated as data, not as a resync.
REQ-025 cpu_rstn goes high on the cycle DONE is entered and stays high until the next SYNC byte or reset.
REQ-026 An error leaves cpu_rstn low; RAM contents already written are not rolled back.
REQ-027 busy is high in every state except IDLE and DONE.
REQ-028 Latency, feature out: last W_LO accepted at cycle n -> mem_we at n+1 -> cpu_rstn high at n+2.

Reset
REQ-029 rstn_ini low asynchronously forces IDLE, cpu_rstn=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, err=0, timer=0, and clears the checksum accumulator.
REQ-030 A reset mid-frame aborts the frame and issues no further writes.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN defined: CHK is expected after the last word; a good load requires CHK == XOR of all frame bytes after SYNC; a match -> DONE one cycle after CHK is accepted; a mismatch -> err set, IDLE.
REQ-032 LOADER_CHECKSUM_EN undefined: the CHK state and its accumulator are absent; the FSM goes from the last WRITE straight to DONE.

Verification
REQ-033 Feature out, frame A5 01 00 03 05 00 0C -> writes addr0=0x305, addr1=0x00C; cpu_rstn high 2 cycles after the last byte; err=0.
REQ-034 Feature in, same frame plus CHK 0x0B -> same writes, then cpu_rstn high; with CHK 0x0C instead -> err=1, cpu_rstn stays low.
REQ-035 A5 00 02 -> err=1, IDLE, no mem_we.
REQ-036 A5 00 00 then a TIMEOUT-cycle gap -> err=1 exactly TIMEOUT cycles after the last byte; a following good frame clears err.
REQ-037 rstn_ini pulsed low after the 4th byte of a 2-word frame -> all outputs at reset values immediately; the second word is never written.
REQ-038 Full frame with count=511 -> 512 writes on addresses 0..511; rx_ready low only in WRITE cycles.
